jerry_move_ctl: RTL and testbench

- Produces Jerry's on-screen top-left position on a pos_if output. The sprite draw stage consumes this position as its pos_if input.
- Samples player key levels and advances horizontal motion and a jump/gravity state machine once per video frame.
- The frame tick is the rising edge of vblnk.
- Sits between the keyboard decoder and the Jerry draw stage.

---
 rtl/jerry_move_ctl_if.sv | 8 +
 rtl/jerry_move_ctl.sv | 139 +++++++++++++
 tb/tb_jerry_move_ctl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/jerry_move_ctl_if.sv
// Screen position bundle passed from the motion controller to the sprite draw stage.
interface pos_if;
  logic [10:0] x;
  logic [10:0] y;

  modport out (output x, output y);
  modport in  (input  x, input  y);
endinterface

// File: rtl/jerry_move_ctl.sv
// Jerry motion controller: per-frame horizontal walking plus a jump/gravity FSM,
// advanced once on each rising edge of vblnk.
module jerry_move_ctl #(
  parameter int unsigned START_X  = 100,
  parameter int unsigned GROUND_Y = 500,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 760,
  parameter int unsigned STEP_X   = 4,
  parameter int unsigned JUMP_V0  = 16,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned V_MAX    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  input  logic key_left,
  input  logic key_right,
  input  logic key_jump,
  pos_if.out   jerry_pos,
  output logic airborne,
  output logic facing_left
);

  typedef enum logic [1:0] {GROUND, RISING, FALLING} state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_vel, w_vel_nxt;
  logic [10:0] r_x, w_x_nxt;
  logic [10:0] r_y, w_y_nxt;
  logic        r_facing, w_facing_nxt;
  logic        r_airborne;
  logic        r_vblnk_q;
  logic        r_armed;
  logic        w_tick;

  // A vblnk already high at reset release must first be seen low before it can tick.
  assign w_tick = vblnk & ~r_vblnk_q & r_armed;

  // Horizontal motion; subtraction is signed 12-bit so it clamps instead of wrapping.
  logic signed [11:0] w_x_sub;
  logic        [11:0] w_x_add;

  always_comb begin
    w_x_sub      = $signed({1'b0, r_x}) - $signed(12'(STEP_X));
    w_x_add      = {1'b0, r_x} + 12'(STEP_X);
    w_x_nxt      = r_x;
    w_facing_nxt = r_facing;
    if (key_left && !key_right) begin
      w_x_nxt      = (w_x_sub < $signed(12'(X_MIN))) ? 11'(X_MIN) : w_x_sub[10:0];
      w_facing_nxt = 1'b1;
    end else if (key_right && !key_left) begin
      w_x_nxt      = (w_x_add > 12'(X_MAX)) ? 11'(X_MAX) : w_x_add[10:0];
      w_facing_nxt = 1'b0;
    end
  end

  // Vertical FSM next-state logic.
  logic [11:0] w_y12;
  logic [11:0] w_vel12;
  logic [6:0]  w_vel_up;
  logic [5:0]  w_vel_fall;
  logic [5:0]  w_vel_dec;
  logic [11:0] w_y_land;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_vel_nxt   = r_vel;
    w_y_nxt     = r_y;
    w_y12       = {1'b0, r_y};
    w_vel12     = {6'd0, r_vel};
    w_vel_up    = {1'b0, r_vel} + 7'(GRAVITY);
    w_vel_fall  = (w_vel_up > 7'(V_MAX)) ? 6'(V_MAX) : w_vel_up[5:0];
    w_vel_dec   = r_vel - 6'(GRAVITY);
    w_y_land    = w_y12 + {6'd0, w_vel_fall};
    unique case (r_state)
      GROUND: begin
        w_y_nxt = 11'(GROUND_Y);
        if (key_jump) begin
          w_state_nxt = RISING;
          w_vel_nxt   = 6'(JUMP_V0);
        end
      end
      RISING: begin
        if (w_vel12 > w_y12) begin
          w_y_nxt     = 11'd0;
          w_vel_nxt   = 6'd0;
          w_state_nxt = FALLING;
        end else begin
          w_y_nxt   = r_y - 11'(r_vel);
          w_vel_nxt = w_vel_dec;
          if (w_vel_dec == 6'd0) w_state_nxt = FALLING;
        end
      end
      FALLING: begin
        if (w_y_land >= 12'(GROUND_Y)) begin
          w_y_nxt     = 11'(GROUND_Y);
          w_vel_nxt   = 6'd0;
          w_state_nxt = GROUND;
        end else begin
          w_y_nxt   = w_y_land[10:0];
          w_vel_nxt = w_vel_fall;
        end
      end
      default: w_state_nxt = GROUND;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= GROUND;
      r_vel      <= 6'd0;
      r_x        <= 11'(START_X);
      r_y        <= 11'(GROUND_Y);
      r_facing   <= 1'b0;
      r_airborne <= 1'b0;
      r_vblnk_q  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      r_vblnk_q <= vblnk;
      if (!vblnk) r_armed <= 1'b1;
      if (w_tick) begin
        r_state    <= w_state_nxt;
        r_vel      <= w_vel_nxt;
        r_x        <= w_x_nxt;
        r_y        <= w_y_nxt;
        r_facing   <= w_facing_nxt;
        r_airborne <= (w_state_nxt != GROUND);
      end
    end
  end

  assign jerry_pos.x = r_x;
  assign jerry_pos.y = r_y;
  assign airborne    = r_airborne;
  assign facing_left = r_facing;

endmodule

// File: tb/tb_jerry_move_ctl.sv
// Directed self-checking bench for jerry_move_ctl: walking limits, jump arc,
// held-jump relaunch, vblnk edge behaviour and asynchronous reset.
module tb_jerry_move_ctl;

  logic clk = 1'b0;
  logic rst;
  logic vblnk;
  logic key_left, key_right, key_jump;
  logic airborne, facing_left;

  pos_if u_pos ();

  jerry_move_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .jerry_pos  (u_pos),
    .airborne   (airborne),
    .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One frame: a short vblnk pulse, then idle; outputs sampled on a falling edge.
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Hand-derived jump arc: k ticks after the launch tick.
  function automatic int jump_y(input int k);
    int y = 500;
    if (k <= 16) begin
      for (int i = 0; i < k; i++) y -= (16 - i);
    end else begin
      y = 364;
      for (int i = 1; i <= k - 16; i++) y += i;
    end
    return y;
  endfunction

  int air_cnt;

  initial begin
    rst = 1'b0; vblnk = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    do_reset();

    check("reset_x", u_pos.x, 100);
    check("reset_y", u_pos.y, 500);
    check("reset_air", airborne, 0);
    check("reset_face", facing_left, 0);

    for (int i = 0; i < 3; i++) begin
      frame();
      check("idle_x", u_pos.x, 100);
      check("idle_y", u_pos.y, 500);
      check("idle_air", airborne, 0);
    end

    // Walk right into the right limit.
    key_right = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      frame();
      check("right_x", u_pos.x, (n < 165) ? 100 + 4 * n : 760);
    end
    check("right_face", facing_left, 0);
    key_right = 1'b0; key_left = 1'b1;
    frame();
    check("left1_x", u_pos.x, 756);
    check("left1_face", facing_left, 1);
    key_left = 1'b0;

    // Walk left from the start into the left limit.
    do_reset();
    key_left = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      frame();
      check("left_x", u_pos.x, (n < 25) ? 100 - 4 * n : 0);
    end
    key_right = 1'b1;
    frame();
    check("both_x", u_pos.x, 0);
    check("both_face", facing_left, 1);
    key_left = 1'b0; key_right = 1'b0;
    frame();
    check("none_face", facing_left, 1);

    // Single-tick jump from the ground.
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    check("jump0_y", u_pos.y, 500);
    check("jump0_air", airborne, 1);
    air_cnt = 1;
    for (int k = 1; k <= 32; k++) begin
      frame();
      check("arc_y", u_pos.y, jump_y(k));
      if (airborne) air_cnt++;
    end
    check("arc_peak", jump_y(16), 364);
    check("land_air", airborne, 0);
    check("air_ticks", air_cnt, 32);
    frame();
    check("post_land_y", u_pos.y, 500);
    check("post_land_air", airborne, 0);

    // Jump held throughout: mid-air presses ignored, relaunch after landing tick.
    key_jump = 1'b1;
    frame();
    for (int k = 1; k <= 32; k++) begin
      frame();
      check("held_y", u_pos.y, jump_y(k));
    end
    check("held_land_air", airborne, 0);
    frame();
    check("relaunch_y", u_pos.y, 500);
    check("relaunch_air", airborne, 1);
    for (int k = 1; k <= 8; k++) frame();
    check("mid_rise_y", u_pos.y, 400);
    key_jump = 1'b0;

    // Asynchronous reset mid-rise, observed before the next rising clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_y", u_pos.y, 500);
    check("async_x", u_pos.x, 100);
    check("async_air", airborne, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    frame();
    check("after_rst_y", u_pos.y, 500);
    check("after_rst_air", airborne, 0);

    // vblnk held high for a long stretch gives exactly one step.
    key_right = 1'b1;
    @(negedge clk) vblnk = 1'b1;
    repeat (1000) @(negedge clk);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_vblnk_x", u_pos.x, 104);

    // vblnk high across reset release: no tick until it drops and rises again.
    @(negedge clk) vblnk = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_vblnk_hi_x", u_pos.x, 100);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vblnk_lo_x", u_pos.x, 100);
    frame();
    check("rst_vblnk_edge_x", u_pos.x, 104);
    key_right = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
